div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high (clk, rst).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  execute-stage divide request, held high by pipeline stall until ready.
REQ-005 signed_div  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start in IDLE.
REQ-006 a  input  32  dividend; sampled with start in IDLE.
REQ-007 b  input  32  divisor; sampled with start in IDLE.
REQ-008 annul  input  1  abort request (exception flush); ends any operation in progress.
REQ-009 ready  output  1  0 = stall execute stage; drives the hazard unit's alu_ready_E.
REQ-010 hi  output  32  remainder; valid only while ready=1 in DONE.
REQ-011 lo  output  32  quotient; valid only while ready=1 in DONE.

Function
REQ-012 The FSM SHALL have states IDLE, BUSY, DONE; state and 6-bit counter SHALL be registered.
REQ-013 ready SHALL be combinational: 1 in DONE; 1 in IDLE when start=0; 0 in IDLE when start=1; 0 in BUSY.
REQ-014 IDLE with start=1 and annul=0, b!=0: latch operand magnitudes and sign flags, clear the 64-bit partial remainder, set counter=0, go to BUSY.
REQ-015 BUSY SHALL perform one radix-2 restoring step per cycle: shift {rem,quo} left 1, subtract |b| from the upper 33 bits, keep the result and set the quotient LSB to 1 if non-negative, otherwise restore and set it to 0.
REQ-016 After step 31 (counter==31), BUSY SHALL go to DONE; total latency from start accept to ready=1 is exactly 33 cycles.
REQ-017 DONE SHALL last exactly one cycle, then go to IDLE unconditionally; start seen in DONE SHALL NOT start a new operation.
REQ-018 Signed results: quotient negated when sign(a)!=sign(b); remainder takes the sign of a; magnitudes computed as 32-bit unsigned.
REQ-019 Signed 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0x00000000 (wrap, no trap).
REQ-020 Divide by zero (b==0 at accept) SHALL go from IDLE directly to DONE in one cycle with lo=0xFFFFFFFF and hi=a, for both signed and unsigned.
REQ-021 annul=1 in any state SHALL force IDLE on the next edge; ready SHALL be driven 1 in that cycle so the flush is not blocked.
REQ-022 Back-to-back divides: start=1 in the cycle after DONE SHALL be accepted normally from IDLE.
REQ-023 hi/lo SHALL hold the last DONE values until the next DONE; the consumer samples them only when ready=1 and start=1.

Reset
REQ-024 rst=1 SHALL force state=IDLE, counter=0, hi=0, lo=0 and all operand/remainder registers to 0 on the next edge, overriding start and annul.
REQ-025 rst asserted mid-BUSY SHALL discard the operation; after reset is released, ready=1 while start=0.

Verification
REQ-026 Unsigned: a=100, b=7, signed_div=0, start held -> ready=0 for 33 cycles, then DONE with lo=14, hi=2, then IDLE.
REQ-027 Signed: a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); a=7, b=-2 -> lo=-3, hi=1.
REQ-028 Overflow and zero: 0x80000000/0xFFFFFFFF signed -> lo=0x80000000, hi=0; a=5, b=0 -> ready=0 for 1 cycle, then lo=0xFFFFFFFF, hi=5.
REQ-029 Abort: start accepted, annul pulsed at BUSY cycle 10 -> ready=1 that cycle, IDLE next, hi/lo unchanged from the previous result.
REQ-030 Reset mid-operation: rst at BUSY cycle 20 -> IDLE, hi=lo=0; a new start=1 then completes in 33 cycles with correct results.
REQ-031 Back-to-back: two divides with start high continuously across DONE -> the second accepted the cycle after DONE; each completes in 33 cycles with correct results.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: 32-bit radix-2 restoring divider (DIV/DIVU) with one-cycle DONE handshake, annul and divide-by-zero.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        annul,
  output logic        ready,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      r_state, w_next;
  logic [5:0]  r_cnt;
  logic [63:0] r_acc;
  logic [31:0] r_bmag, r_hi, r_lo;
  logic        r_negq, r_negr;
  logic [31:0] w_amag, w_bmag, w_quo, w_rem;
  logic [64:0] w_sh;
  logic [32:0] w_diff;
  logic [63:0] w_step;
  assign w_amag = (signed_div && a[31]) ? -a : a;
  assign w_bmag = (signed_div && b[31]) ? -b : b;
  // {rem,quo} shifted left; upper 33 bits hold the trial remainder
  assign w_sh   = {r_acc, 1'b0};
  assign w_diff = w_sh[64:32] - {1'b0, r_bmag};
  assign w_step = w_diff[32] ? w_sh[63:0] : {w_diff[31:0], w_sh[31:1], 1'b1};
  assign w_quo  = w_step[31:0];
  assign w_rem  = w_step[63:32];
  assign hi = r_hi;
  assign lo = r_lo;
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    ready  = 1'b0;
    case (r_state)
      IDLE: begin
        ready = !start;
        if (start) w_next = (b == 32'd0) ? DONE : BUSY;
      end
      BUSY: if (r_cnt == 6'd31) w_next = DONE;
      DONE: begin
        ready  = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (annul) begin
      ready  = 1'b1;
      w_next = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= 6'd0;
      r_acc  <= 64'd0;
      r_bmag <= 32'd0;
      r_negq <= 1'b0;
      r_negr <= 1'b0;
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
    end else if (!annul) begin
      case (r_state)
        IDLE: if (start) begin
          if (b == 32'd0) begin
            r_lo <= 32'hFFFF_FFFF;
            r_hi <= a;
          end else begin
            r_acc  <= {32'd0, w_amag};
            r_bmag <= w_bmag;
            r_negq <= signed_div && (a[31] ^ b[31]);
            r_negr <= signed_div && a[31];
            r_cnt  <= 6'd0;
          end
        end
        BUSY: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) begin
            r_lo <= r_negq ? -w_quo : w_quo;
            r_hi <= r_negr ? -w_rem : w_rem;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vector table plus abort, reset and back-to-back sequences for div_unit.
module tb_div_unit;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, signed_div = 1'b0, annul = 1'b0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic        ready;
  logic [31:0] hi, lo;
  int checks = 0, errors = 0;

  div_unit dut (.clk(clk), .rst(rst), .start(start), .signed_div(signed_div), .a(a), .b(b),
                .annul(annul), .ready(ready), .hi(hi), .lo(lo));

  always #5 clk = ~clk;

  typedef struct {
    logic        sg;
    logic [31:0] a, b, lo, hi;
    int          lat;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in an IDLE cycle; returns in the IDLE cycle after DONE.
  task automatic run_div(input string name, input logic sg, input logic [31:0] va, vb,
                         input logic [31:0] elo, ehi, input int elat, input logic keep);
    int n = 0;
    signed_div = sg; a = va; b = vb; start = 1'b1;
    #1;
    while (!ready && n < 100) begin
      step();
      n++;
    end
    chk({name, " latency"}, n, elat);
    chk({name, " lo"}, lo, elo);
    chk({name, " hi"}, hi, ehi);
    step();
    if (!keep) begin
      start = 1'b0;
      #1;
      chk({name, " idle ready"}, {31'd0, ready}, 32'd1);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33};
    vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33};
    vecs[4]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1};
    vecs[5]  = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1};
    vecs[6]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33};
    vecs[7]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  33};
    vecs[8]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  33};
    vecs[9]  = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          33};
    vecs[10] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          33};
    vecs[11] = '{1'b1, 32'h7FFF_FFFF,  32'd16,         32'h07FF_FFFF,  32'd15,         33};

    step();
    step();
    rst = 1'b0;
    #1;
    chk("reset ready", {31'd0, ready}, 32'd1);
    chk("reset lo", lo, 32'd0);
    chk("reset hi", hi, 32'd0);

    for (int i = 0; i < 12; i++) run_div($sformatf("vec%0d", i), vecs[i].sg, vecs[i].a, vecs[i].b,
                                         vecs[i].lo, vecs[i].hi, vecs[i].lat, 1'b0);

    // annul while requesting in IDLE must not stall
    start = 1'b1; annul = 1'b1; a = 32'd9; b = 32'd3; signed_div = 1'b0;
    #1;
    chk("idle annul ready", {31'd0, ready}, 32'd1);
    step();
    annul = 1'b0; start = 1'b0;
    #1;
    chk("idle annul no-op lo", lo, 32'h07FF_FFFF);

    // abort at BUSY cycle 10
    start = 1'b1; a = 32'd100; b = 32'd7;
    step();
    for (int i = 0; i < 10; i++) step();
    chk("busy stalls", {31'd0, ready}, 32'd0);
    annul = 1'b1;
    #1;
    chk("abort ready", {31'd0, ready}, 32'd1);
    step();
    annul = 1'b0; start = 1'b0;
    #1;
    chk("abort idle ready", {31'd0, ready}, 32'd1);
    chk("abort lo kept", lo, 32'h07FF_FFFF);
    chk("abort hi kept", hi, 32'd15);
    run_div("after abort", 1'b0, 32'd50, 32'd6, 32'd8, 32'd2, 33, 1'b0);

    // reset at BUSY cycle 20
    start = 1'b1; a = 32'd1000; b = 32'd3;
    step();
    for (int i = 0; i < 20; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    #1;
    chk("midrst ready", {31'd0, ready}, 32'd1);
    chk("midrst lo", lo, 32'd0);
    chk("midrst hi", hi, 32'd0);
    run_div("after rst", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 33, 1'b0);

    // back-to-back with start held across DONE
    run_div("b2b first", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b1);
    run_div("b2b second", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
